// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler: stages display updates from the elevator FSM and the
// people generator, and commits them to the pixel_gen-facing registers only
// at the start of vertical blanking, so a frame never mixes old and new data.

module vga_frame_scheduler #(
    parameter int unsigned VERT_ACTIVE = 480,
    parameter int unsigned DEST_W      = 8,
    parameter int unsigned PEOPLE_W    = 26
) (
    input  logic                pixel_clk,
    input  logic                reset_n,
    input  logic [9:0]          horiz_count,
    input  logic [9:0]          vert_count,
    input  logic                hold,
    input  logic                dest_req,
    input  logic [DEST_W-1:0]   dest_in,
    input  logic [1:0]          state_in,
    output logic                dest_ack,
    input  logic                ppl_req,
    input  logic [PEOPLE_W-1:0] ppl_in,
    output logic                ppl_ack,
    output logic [DEST_W-1:0]   destination,
    output logic [1:0]          sim_state,
    output logic [PEOPLE_W-1:0] people_data,
    output logic                commit_pulse,
    output logic [7:0]          frame_count,
    output logic                pending
);

    localparam logic [9:0] VertActiveLine = 10'(VERT_ACTIVE);

    typedef enum logic [1:0] {
        StActive,
        StCommit,
        StBlank
    } state_e;

    state_e state_q, state_d;

    // Staging slots
    logic                dest_full_q, dest_full_d;
    logic [DEST_W-1:0]   dest_stage_q, dest_stage_d;
    logic [1:0]          st_stage_q, st_stage_d;
    logic                dest_ack_q;

    logic                ppl_full_q, ppl_full_d;
    logic [PEOPLE_W-1:0] ppl_stage_q, ppl_stage_d;
    logic                ppl_ack_q;

    // Committed outputs
    logic [DEST_W-1:0]   destination_q, destination_d;
    logic [1:0]          sim_state_q, sim_state_d;
    logic [PEOPLE_W-1:0] people_q, people_d;
    logic                commit_pulse_q, commit_pulse_d;
    logic [7:0]          frame_count_q, frame_count_d;
    logic                pending_q;

    logic at_boundary;
    logic at_top;
    logic in_commit;
    logic do_commit;
    logic dest_cap;
    logic ppl_cap;

    // Decode timing points and the per-cycle capture/commit qualifiers
    always_comb begin
        at_boundary = (vert_count == VertActiveLine) && (horiz_count == 10'd0);
        at_top      = (vert_count == 10'd0) && (horiz_count == 10'd0);
        in_commit   = (state_q == StCommit);
        do_commit   = in_commit && !hold;
        dest_cap    = dest_req && !dest_full_q && !in_commit;
        ppl_cap     = ppl_req && !ppl_full_q && !in_commit;
    end

    // Frame FSM next-state: boundary only honoured in ACTIVE, so one commit per frame
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StActive: if (at_boundary) state_d = StCommit;
            StCommit: state_d = StBlank;
            StBlank:  if (at_top) state_d = StActive;
            default:  state_d = StActive;
        endcase
    end

    // Frame FSM state register
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StActive;
        end else begin
            state_q <= state_d;
        end
    end

    // Elevator slot next-state: capture when empty, clear on a committed frame
    always_comb begin
        dest_full_d  = dest_full_q;
        dest_stage_d = dest_stage_q;
        st_stage_d   = st_stage_q;
        if (dest_cap) begin
            dest_full_d  = 1'b1;
            dest_stage_d = dest_in;
            st_stage_d   = state_in;
        end else if (do_commit) begin
            dest_full_d = 1'b0;
        end
    end

    // People slot next-state: same rules as the elevator slot
    always_comb begin
        ppl_full_d  = ppl_full_q;
        ppl_stage_d = ppl_stage_q;
        if (ppl_cap) begin
            ppl_full_d  = 1'b1;
            ppl_stage_d = ppl_in;
        end else if (do_commit) begin
            ppl_full_d = 1'b0;
        end
    end

    // Staging slot registers and capture acknowledges
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            dest_full_q  <= 1'b0;
            dest_stage_q <= '0;
            st_stage_q   <= 2'b00;
            dest_ack_q   <= 1'b0;
            ppl_full_q   <= 1'b0;
            ppl_stage_q  <= '0;
            ppl_ack_q    <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            dest_full_q  <= dest_full_d;
            dest_stage_q <= dest_stage_d;
            st_stage_q   <= st_stage_d;
            dest_ack_q   <= dest_cap;
            ppl_full_q   <= ppl_full_d;
            ppl_stage_q  <= ppl_stage_d;
            ppl_ack_q    <= ppl_cap;
            // Registered copy of the next flags, so pending tracks the slots exactly
            pending_q    <= dest_full_d | ppl_full_d;
        end
    end

    // Commit next-state: copy only full slots; hold skips the copy but not the count
    always_comb begin
        destination_d  = destination_q;
        sim_state_d    = sim_state_q;
        people_d       = people_q;
        commit_pulse_d = 1'b0;
        frame_count_d  = frame_count_q;
        if (in_commit) begin
            frame_count_d = frame_count_q + 8'd1;
        end
        if (do_commit) begin
            commit_pulse_d = dest_full_q | ppl_full_q;
            if (dest_full_q) begin
                destination_d = dest_stage_q;
                sim_state_d   = st_stage_q;
            end
            if (ppl_full_q) begin
                people_d = ppl_stage_q;
            end
        end
    end

    // Committed output registers feeding pixel_gen
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            destination_q  <= '0;
            sim_state_q    <= 2'b00;
            people_q       <= '0;
            commit_pulse_q <= 1'b0;
            frame_count_q  <= 8'd0;
        end else begin
            destination_q  <= destination_d;
            sim_state_q    <= sim_state_d;
            people_q       <= people_d;
            commit_pulse_q <= commit_pulse_d;
            frame_count_q  <= frame_count_d;
        end
    end

    assign dest_ack     = dest_ack_q;
    assign ppl_ack      = ppl_ack_q;
    assign destination  = destination_q;
    assign sim_state    = sim_state_q;
    assign people_data  = people_q;
    assign commit_pulse = commit_pulse_q;
    assign frame_count  = frame_count_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Self-checking bench for vga_frame_scheduler: directed test-plan steps plus
// randomized requesters and timing points, checked every cycle against a
// transaction-level model of staging, frame boundaries and commits.

module tb_vga_frame_scheduler;

    logic        pixel_clk = 1'b0;
    logic        reset_n   = 1'b0;
    logic [9:0]  horiz_count = '0;
    logic [9:0]  vert_count  = '0;
    logic        hold     = 1'b0;
    logic        dest_req = 1'b0;
    logic [7:0]  dest_in  = '0;
    logic [1:0]  state_in = '0;
    logic        dest_ack;
    logic        ppl_req  = 1'b0;
    logic [25:0] ppl_in   = '0;
    logic        ppl_ack;
    logic [7:0]  destination;
    logic [1:0]  sim_state;
    logic [25:0] people_data;
    logic        commit_pulse;
    logic [7:0]  frame_count;
    logic        pending;

    vga_frame_scheduler dut (
        .pixel_clk   (pixel_clk),
        .reset_n     (reset_n),
        .horiz_count (horiz_count),
        .vert_count  (vert_count),
        .hold        (hold),
        .dest_req    (dest_req),
        .dest_in     (dest_in),
        .state_in    (state_in),
        .dest_ack    (dest_ack),
        .ppl_req     (ppl_req),
        .ppl_in      (ppl_in),
        .ppl_ack     (ppl_ack),
        .destination (destination),
        .sim_state   (sim_state),
        .people_data (people_data),
        .commit_pulse(commit_pulse),
        .frame_count (frame_count),
        .pending     (pending)
    );

    always #5 pixel_clk = ~pixel_clk;

    int passed = 0;
    int total  = 0;

    // Reference model: what each slot holds, what pixel_gen shows, and whether
    // the next frame boundary may still fire.
    bit          m_dest_full, m_ppl_full;
    logic [7:0]  m_dest_stage;
    logic [1:0]  m_st_stage;
    logic [25:0] m_ppl_stage;
    logic [7:0]  m_dest_out;
    logic [1:0]  m_st_out;
    logic [25:0] m_ppl_out;
    bit          m_pulse, m_dack, m_pack, m_pending;
    logic [7:0]  m_fc;
    bit          m_armed;       // boundary for this frame not yet taken
    bit          m_waiting_top; // commit done, waiting for top of frame
    bit          m_commit_now;  // this cycle is the commit cycle

    bit          auto_req = 1'b0;
    int          pulse_cnt;
    logic [7:0]  snap_dest;
    logic [1:0]  snap_state;
    logic [25:0] snap_ppl;
    bit          snap_pulse, snap_pending, snap_pack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_dest_full = 0; m_ppl_full = 0;
        m_dest_stage = '0; m_st_stage = '0; m_ppl_stage = '0;
        m_dest_out = '0; m_st_out = '0; m_ppl_out = '0;
        m_pulse = 0; m_dack = 0; m_pack = 0; m_pending = 0; m_fc = '0;
        m_armed = 1; m_waiting_top = 0; m_commit_now = 0;
    endtask

    // Advance the model across one clock edge using the inputs now applied
    task automatic model_step();
        bit cap_d, cap_p, was_commit;
        cap_d = dest_req && !m_dest_full && !m_commit_now;
        cap_p = ppl_req && !m_ppl_full && !m_commit_now;
        m_pulse = 0;
        if (m_commit_now) begin
            m_fc = m_fc + 8'd1;
            if (!hold) begin
                m_pulse = m_dest_full || m_ppl_full;
                if (m_dest_full) begin
                    m_dest_out = m_dest_stage; m_st_out = m_st_stage; m_dest_full = 0;
                end
                if (m_ppl_full) begin
                    m_ppl_out = m_ppl_stage; m_ppl_full = 0;
                end
            end
        end
        m_dack = cap_d;
        m_pack = cap_p;
        if (cap_d) begin
            m_dest_full = 1; m_dest_stage = dest_in; m_st_stage = state_in;
        end
        if (cap_p) begin
            m_ppl_full = 1; m_ppl_stage = ppl_in;
        end
        was_commit = m_commit_now;
        m_commit_now = 0;
        if (m_armed && vert_count == 10'd480 && horiz_count == 10'd0) begin
            m_armed = 0; m_commit_now = 1;
        end else if (was_commit) begin
            m_waiting_top = 1;
        end else if (m_waiting_top && vert_count == 10'd0 && horiz_count == 10'd0) begin
            m_waiting_top = 0; m_armed = 1;
        end
        m_pending = m_dest_full || m_ppl_full;
    endtask

    // One clock: predict, clock, compare every output, then act as the requesters
    task automatic tick();
        model_step();
        @(posedge pixel_clk);
        #1;
        chk("dest_ack",     32'(dest_ack),     32'(m_dack));
        chk("ppl_ack",      32'(ppl_ack),      32'(m_pack));
        chk("destination",  32'(destination),  32'(m_dest_out));
        chk("sim_state",    32'(sim_state),    32'(m_st_out));
        chk("people_data",  32'(people_data),  32'(m_ppl_out));
        chk("commit_pulse", 32'(commit_pulse), 32'(m_pulse));
        chk("frame_count",  32'(frame_count),  32'(m_fc));
        chk("pending",      32'(pending),      32'(m_pending));
        if (commit_pulse) pulse_cnt++;
        if (dest_req && m_dack) dest_req = 1'b0;
        if (ppl_req && m_pack) ppl_req = 1'b0;
        if (auto_req) begin
            if (!dest_req && $urandom_range(0, 3) == 0) begin
                dest_req = 1'b1; dest_in = 8'($urandom); state_in = 2'($urandom);
            end
            if (!ppl_req && $urandom_range(0, 3) == 0) begin
                ppl_req = 1'b1; ppl_in = 26'($urandom);
            end
        end
    endtask

    task automatic at(input int v, input int h);
        vert_count  = 10'(v);
        horiz_count = 10'(h);
        tick();
    endtask

    // One compressed frame: boundary, commit, repeated line-480 h=0 points, top of frame
    task automatic frame(input bit hv);
        logic [7:0] fc0;
        fc0 = m_fc;
        pulse_cnt = 0;
        at(479, 799);
        hold = hv;
        at(480, 0);
        at(480, 1);
        hold = 1'b0;
        snap_dest = destination; snap_state = sim_state; snap_ppl = people_data;
        snap_pulse = commit_pulse; snap_pending = pending;
        at(480, 2);
        snap_pack = ppl_ack;
        at(480, 0);
        at(480, 0);
        at(481, 0);
        at(0, 0);
        at(0, 1);
        at(100, 5);
        chk("frame_step", 32'(frame_count), 32'(8'(fc0 + 8'd1)));
        if (fc0 == 8'hFF) chk("wrap_to_zero", 32'(frame_count), 32'd0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge pixel_clk);
        chk("rst_dest",    32'(destination),  32'd0);
        chk("rst_people",  32'(people_data),  32'd0);
        chk("rst_fc",      32'(frame_count),  32'd0);
        chk("rst_pending", 32'(pending),      32'd0);
        chk("rst_acks",    32'({dest_ack, ppl_ack, commit_pulse}), 32'd0);
        reset_n = 1'b1;

        // Single elevator update
        dest_in = 8'h05; state_in = 2'b10; dest_req = 1'b1;
        at(100, 10);
        chk("single_ack", 32'(dest_ack), 32'd1);
        at(100, 11);
        chk("single_ack_pulse", 32'(dest_ack), 32'd0);
        chk("single_pending", 32'(pending), 32'd1);
        frame(1'b0);
        chk("single_dest", 32'(snap_dest), 32'h05);
        chk("single_state", 32'(snap_state), 32'd2);
        chk("single_pulse", 32'(snap_pulse), 32'd1);
        chk("single_pulse_cnt", 32'(pulse_cnt), 32'd1);

        // Backpressure on the people slot
        ppl_in = 26'h1; ppl_req = 1'b1;
        at(100, 20);
        chk("bp_first_ack", 32'(ppl_ack), 32'd1);
        ppl_in = 26'h2; ppl_req = 1'b1;
        at(100, 21);
        at(100, 22);
        chk("bp_withheld", 32'(ppl_ack), 32'd0);
        frame(1'b0);
        chk("bp_commit1", 32'(snap_ppl), 32'h1);
        chk("bp_ack_after_commit", 32'(snap_pack), 32'd1);
        frame(1'b0);
        chk("bp_commit2", 32'(snap_ppl), 32'h2);

        // Concurrent requests
        dest_in = 8'hA7; state_in = 2'b01; dest_req = 1'b1;
        ppl_in = 26'h2ABCDEF; ppl_req = 1'b1;
        at(100, 30);
        chk("conc_acks", 32'({dest_ack, ppl_ack}), 32'd3);
        frame(1'b0);
        chk("conc_dest", 32'(snap_dest), 32'hA7);
        chk("conc_ppl", 32'(snap_ppl), 32'h2ABCDEF);
        chk("conc_pulse_cnt", 32'(pulse_cnt), 32'd1);

        // Hold skips a commit but still counts the frame
        dest_in = 8'h33; state_in = 2'b11; dest_req = 1'b1;
        at(100, 40);
        frame(1'b1);
        chk("hold_dest", 32'(snap_dest), 32'hA7);
        chk("hold_pulse", 32'(snap_pulse), 32'd0);
        chk("hold_pending", 32'(snap_pending), 32'd1);
        frame(1'b0);
        chk("hold_release_dest", 32'(snap_dest), 32'h33);
        chk("hold_release_state", 32'(snap_state), 32'd3);

        // Mid-frame reset with both slots full
        dest_in = 8'h77; dest_req = 1'b1; ppl_in = 26'h5; ppl_req = 1'b1;
        at(100, 50);
        @(negedge pixel_clk);
        #2 reset_n = 1'b0;
        dest_req = 1'b0; ppl_req = 1'b0;
        #1;
        chk("mid_rst_outputs", 32'({destination, sim_state, frame_count}), 32'd0);
        chk("mid_rst_people", 32'(people_data), 32'd0);
        chk("mid_rst_flags", 32'({dest_ack, ppl_ack, commit_pulse, pending}), 32'd0);
        model_reset();
        @(negedge pixel_clk);
        reset_n = 1'b1;
        at(200, 3);
        frame(1'b0);
        chk("mid_rst_no_pulse", 32'(snap_pulse), 32'd0);
        chk("mid_rst_fc", 32'(frame_count), 32'd1);

        // 256 frames: frame_count wraps, each frame counted exactly once
        for (int i = 0; i < 256; i++) frame(1'b0);

        // Randomized requesters and arbitrary timing-generator jumps
        auto_req = 1'b1;
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 5));
            hold = ($urandom_range(0, 3) == 0);
            if (r == 0) at(480, 0);
            else if (r == 1) at(0, 0);
            else at(int'($urandom_range(0, 524)), int'($urandom_range(0, 799)));
        end
        hold = 1'b0;
        at(100, 1);
        at(0, 0);
        at(0, 0);
        at(100, 1);
        for (int i = 0; i < 30; i++) frame($urandom_range(0, 3) == 0);
        auto_req = 1'b0;
        repeat (4) at(100, 9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vga_frame_scheduler.md
# vga_frame_scheduler

Frame-synchronous update scheduler between the elevator simulation core and the VGA pixel generator. It accepts display updates from two independent requesters, the elevator FSM (destination and sim_state) and the people generator (people_data), through a req/ack handshake, and stages each update in a one-deep slot. It commits staged updates to the registers that feed pixel_gen only at the start of vertical blanking, so no frame is ever drawn with mixed old and new data. It sits beside vgaController in the pixel clock domain and is driven by that controller's horiz_count and vert_count.

## Interface
Parameters:
- VERT_ACTIVE, default 480: first blanking line; the commit trigger line.
- DEST_W, default 8: width of destination.
- PEOPLE_W, default 26: width of people_data.

Ports:
- pixel_clk  input  1  pixel clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- horiz_count  input  10  current horizontal count from the VGA timing generator.
- vert_count  input  10  current vertical count from the VGA timing generator.
- hold  input  1  when high at a frame boundary, that frame's commit is skipped.
- dest_req  input  1  elevator requester: update valid; held until dest_ack.
- dest_in  input  DEST_W  elevator requester: destination value.
- state_in  input  2  elevator requester: sim_state value.
- dest_ack  output  1  one-cycle pulse; dest_in and state_in were captured.
- ppl_req  input  1  people requester: update valid; held until ppl_ack.
- ppl_in  input  PEOPLE_W  people requester: people_data value.
- ppl_ack  output  1  one-cycle pulse; ppl_in was captured.
- destination  output  DEST_W  committed destination, to pixel_gen.
- sim_state  output  2  committed simulation state, to pixel_gen.
- people_data  output  PEOPLE_W  committed people data, to pixel_gen.
- commit_pulse  output  1  one-cycle pulse when a commit loads the outputs.
- frame_count  output  8  frame boundaries seen; wraps 255 to 0.
- pending  output  1  high while either staging slot is full.

## Operation
- Each requester has its own staging slot: a data register plus a full flag.
- Capture: if req is high, the slot is empty, and the FSM is not in COMMIT, capture the data at the clock edge, set full, and assert ack for the following cycle only.
- If the slot is full, ack is withheld. The requester holds req and its data stable (backpressure). No overrun is possible.
- The requesters never contend: each slot is independent, and both can be acked in the same cycle.
- FSM states:
  - ACTIVE: waits for vert_count == VERT_ACTIVE and horiz_count == 0, then moves to COMMIT.
  - COMMIT: lasts exactly one cycle, then moves to BLANK. Captures are blocked in this cycle.
  - BLANK: waits for vert_count == 0 and horiz_count == 0, then moves to ACTIVE.
- The boundary match is evaluated only in ACTIVE, so a frame can never commit twice.
- COMMIT cycle actions:
  - frame_count increments, always, regardless of hold.
  - If hold is low: each full slot is copied to its outputs and cleared. Empty slots leave their outputs unchanged. commit_pulse is asserted if at least one slot was full.
  - If hold is high: nothing is copied or cleared, and commit_pulse stays low.
- pending = dest_full OR ppl_full (registered flags, no combinational path from req).
- All outputs are registered.

## Timing
- Reset (reset_n low, asynchronous): FSM to ACTIVE; both slots empty; destination, sim_state, people_data, frame_count = 0; dest_ack, ppl_ack, commit_pulse, pending = 0.
- Reset mid-operation discards staged data and any in-flight ack.
- Request to ack: req is sampled high with the slot empty in cycle T, and ack is high in cycle T+1. The requester may drop req in T+2.
- Commit latency: boundary match in cycle T puts the FSM in COMMIT for T+1. New outputs, commit_pulse, the incremented frame_count, and cleared slots are visible in T+2.
- Simultaneous events:
  - A req arriving during the COMMIT cycle is not captured that cycle. Because the slots are cleared at that edge, it is captured in T+2 and its ack appears in T+3. That data waits for the next frame.
  - A req captured in BLANK or late ACTIVE, before the boundary, is committed at that boundary.
- vert_count/horiz_count discontinuities, such as a timing-generator reset, do not break the FSM. In BLANK it waits for the 0/0 point. In ACTIVE it waits for the boundary.

## Test plan
- Reset: assert reset_n=0 mid-frame with both slots full -> all outputs 0, pending=0, FSM in ACTIVE. The next boundary produces commit_pulse=0 and frame_count=1.
- Single update: dest_req with dest_in=8'h05 and state_in=2'b10 at vert_count=100 -> dest_ack 1 cycle later. destination=05 and sim_state=10 appear 2 cycles after (vert_count=480, horiz_count=0), with commit_pulse high for 1 cycle.
- Backpressure: two ppl updates (26'h1 then 26'h2) in the same frame -> first acked; second held unacked until the commit. Commit 1 yields people_data=1. The second is acked 1 cycle after the commit and appears next frame.
- Concurrent: dest_req and ppl_req in the same cycle -> both acks in the same cycle; both outputs update on the same commit_pulse.
- Hold: hold=1 at a boundary with dest staged -> no output change, commit_pulse=0, frame_count increments, pending stays 1. With hold=0, the next frame commits.
- Wrap and no double commit: run 256 frames -> frame_count goes 255 to 0. Holding vert_count at 480 for multiple lines produces exactly one COMMIT.
